// File: rtl/mult_div_sequencer_if.sv
// Pipeline-control handshake and ALU operand bus for the iterative MULTU/DIVU sequencer.
// The sequencer is the slave on start/op/rs/rt and the initiator on the ALU operand lines.
interface mult_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] aluIn1;
  logic [WIDTH-1:0] aluIn2;
  logic [3:0]       aluCtl;
  logic [WIDTH-1:0] aluResult;

  // Handshake: start/op/rs/rt are taken only while busy is low; busy stays high
  // from the cycle after acceptance through the single-cycle done pulse, and
  // hi/lo are valid from the done cycle until the next done.
  modport slave (
    input  start, op, rs, rt, aluResult,
    output busy, done, hi, lo, aluIn1, aluIn2, aluCtl
  );

  modport master (
    output start, op, rs, rt, aluResult,
    input  busy, done, hi, lo, aluIn1, aluIn2, aluCtl
  );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative unsigned 32x32 MULTU (shift-add) and DIVU (restoring shift-subtract) unit.
// One ALU add or subtract per RUN cycle; the result lands in hi/lo on entry to DONE.
module mult_div_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] CTL_ADD = 4'b0010,
  parameter logic [3:0] CTL_SUB = 4'b0110
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_div_sequencer_if.slave bus,
  output logic [1:0]          dbg_state
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             op_q;
  logic [WIDTH-1:0] wh, wl, wd;
  logic [WIDTH-1:0] wh_nx, wl_nx, s, m;
  logic             c, b, qbit;

  assign dbg_state = state;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // wh/wl hold H/L for MULTU and R/Q for DIVU; wd holds multiplicand or divisor.
  always_comb begin
    bus.aluIn1 = '0;
    bus.aluIn2 = '0;
    bus.aluCtl = 4'b0000;
    s          = {wh[WIDTH-2:0], wl[WIDTH-1]};
    m          = wl[0] ? wd : '0;
    c          = 1'b0;
    b          = 1'b0;
    qbit       = 1'b0;
    wh_nx      = wh;
    wl_nx      = wl;
    if (state == RUN) begin
      if (!op_q) begin
        bus.aluIn1 = wh;
        bus.aluIn2 = m;
        bus.aluCtl = CTL_ADD;
        c     = (wh[WIDTH-1] & m[WIDTH-1]) |
                ((wh[WIDTH-1] | m[WIDTH-1]) & ~bus.aluResult[WIDTH-1]);
        wh_nx = {c, bus.aluResult[WIDTH-1:1]};
        wl_nx = {bus.aluResult[0], wl[WIDTH-1:1]};
      end else begin
        bus.aluIn1 = s;
        bus.aluIn2 = wd;
        bus.aluCtl = CTL_SUB;
        b     = (~s[WIDTH-1] & wd[WIDTH-1]) |
                ((~s[WIDTH-1] | wd[WIDTH-1]) & bus.aluResult[WIDTH-1]);
        // The bit shifted out of R acts as a 33rd remainder bit: if set, S >= D regardless.
        qbit  = wh[WIDTH-1] | ~b;
        wh_nx = qbit ? bus.aluResult : s;
        wl_nx = {wl[WIDTH-2:0], qbit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      op_q   <= 1'b0;
      wh     <= '0;
      wl     <= '0;
      wd     <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op;
          count <= '0;
          wh    <= '0;
          wl    <= bus.op ? bus.rs : bus.rt;
          wd    <= bus.op ? bus.rt : bus.rs;
        end
        RUN: begin
          wh <= wh_nx;
          wl <= wl_nx;
          if (count == LAST) begin
            count  <= '0;
            bus.hi <= wh_nx;
            bus.lo <= wl_nx;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
